// File: rtl/vx_smem_switch_if.sv
// Shared-memory switch bus: per-lane request bundle plus a single merged response channel.
// The master drives requests and response-ready; the slave drives request-ready and responses.
interface vx_smem_switch_if #(
  parameter int unsigned NUM_REQS  = 4,
  parameter int unsigned WORD_SIZE = 4,
  parameter int unsigned TAG_WIDTH = 16
);
  logic [NUM_REQS-1:0]                  req_valid;
  logic [NUM_REQS-1:0]                  req_rw;
  logic [NUM_REQS-1:0][29:0]            req_addr;
  logic [NUM_REQS-1:0][WORD_SIZE-1:0]   req_byteen;
  logic [NUM_REQS-1:0][8*WORD_SIZE-1:0] req_data;
  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]   req_tag;
  logic [NUM_REQS-1:0]                  req_ready;

  logic                                 rsp_valid;
  logic [NUM_REQS-1:0]                  rsp_tmask;
  logic [NUM_REQS-1:0][8*WORD_SIZE-1:0] rsp_data;
  logic [TAG_WIDTH-1:0]                 rsp_tag;
  logic                                 rsp_ready;

  modport master (
    output req_valid, req_rw, req_addr, req_byteen, req_data, req_tag,
    input  req_ready,
    input  rsp_valid, rsp_tmask, rsp_data, rsp_tag,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_byteen, req_data, req_tag,
    output req_ready,
    output rsp_valid, rsp_tmask, rsp_data, rsp_tag,
    input  rsp_ready
  );
endinterface

// File: rtl/vx_smem_switch.sv
// Splits LSU lane requests between cache and shared memory by tag bit 0, and merges the two
// response streams round-robin. Define VX_SMEM_SWITCH_PERF_EN to add smem read/write counters.
`ifdef VX_SMEM_SWITCH_PERF_EN
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif
`endif

module vx_smem_switch #(
  parameter int unsigned NUM_REQS  = 4,
  parameter int unsigned WORD_SIZE = 4,
  parameter int unsigned TAG_WIDTH = 16
) (
  input logic              clk,
  input logic              reset,
  vx_smem_switch_if.slave  core_bus,
  vx_smem_switch_if.master cache_bus,
  vx_smem_switch_if.master smem_bus
`ifdef VX_SMEM_SWITCH_PERF_EN
  ,
  output logic [`PERF_CTR_BITS-1:0] perf_smem_reads,
  output logic [`PERF_CTR_BITS-1:0] perf_smem_writes
`endif
);
  localparam int unsigned PayW = 1 + 30 + WORD_SIZE + 8 * WORD_SIZE + TAG_WIDTH;
  typedef logic [PayW-1:0] pay_t;

  // Index 0 = cache port, 1 = smem port.
  logic [1:0][NUM_REQS-1:0] buf_push, buf_pop, buf_free, buf_valid, out_ready;
  pay_t                     buf_head [2][NUM_REQS];
  pay_t                     in_pay   [NUM_REQS];
  logic [NUM_REQS-1:0]      sel_smem;

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_lane
    assign sel_smem[i] = core_bus.req_tag[i][0];
    assign in_pay[i]   = {core_bus.req_rw[i], core_bus.req_addr[i], core_bus.req_byteen[i],
                          core_bus.req_data[i], core_bus.req_tag[i]};
    assign core_bus.req_ready[i] = reset & (sel_smem[i] ? buf_free[1][i] : buf_free[0][i]);
    assign out_ready[0][i] = cache_bus.req_ready[i];
    assign out_ready[1][i] = smem_bus.req_ready[i];

    assign {cache_bus.req_rw[i], cache_bus.req_addr[i], cache_bus.req_byteen[i],
            cache_bus.req_data[i], cache_bus.req_tag[i]} = buf_head[0][i];
    assign {smem_bus.req_rw[i], smem_bus.req_addr[i], smem_bus.req_byteen[i],
            smem_bus.req_data[i], smem_bus.req_tag[i]} = buf_head[1][i];

    for (genvar p = 0; p < 2; p++) begin : g_port
      logic [1:0] cnt_q, cnt_d;
      pay_t       slot0_q, slot0_d, slot1_q, slot1_d;

      assign buf_valid[p][i] = (cnt_q != 2'd0);
      assign buf_pop[p][i]   = buf_valid[p][i] & out_ready[p][i];
      // A full buffer still accepts when its head leaves this cycle.
      assign buf_free[p][i]  = (cnt_q != 2'd2) | buf_pop[p][i];
      assign buf_push[p][i]  = core_bus.req_valid[i] & (sel_smem[i] == 1'(p)) & buf_free[p][i];
      assign buf_head[p][i]  = slot0_q;

      always_comb begin
        cnt_d   = cnt_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (buf_pop[p][i]) begin
          slot0_d = slot1_q;
          cnt_d   = cnt_d - 2'd1;
        end
        if (buf_push[p][i]) begin
          if (cnt_d == 2'd0) slot0_d = in_pay[i];
          else               slot1_d = in_pay[i];
          cnt_d = cnt_d + 2'd1;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_q   <= 2'd0;
          slot0_q <= '0;
          slot1_q <= '0;
        end else begin
          cnt_q   <= cnt_d;
          slot0_q <= slot0_d;
          slot1_q <= slot1_d;
        end
      end
    end
  end

  assign cache_bus.req_valid = buf_valid[0];
  assign smem_bus.req_valid  = buf_valid[1];

  // Response merge: rr_q set means smem wins the next tie.
  logic                                 rr_q;
  logic                                 grant_smem, can_load, cache_fire, smem_fire;
  logic                                 rsp_valid_q;
  logic [NUM_REQS-1:0]                  rsp_tmask_q;
  logic [NUM_REQS-1:0][8*WORD_SIZE-1:0] rsp_data_q;
  logic [TAG_WIDTH-1:0]                 rsp_tag_q;

  always_comb begin
    grant_smem          = smem_bus.rsp_valid & (~cache_bus.rsp_valid | rr_q);
    can_load            = ~rsp_valid_q | core_bus.rsp_ready;
    cache_bus.rsp_ready = reset & ~grant_smem & can_load;
    smem_bus.rsp_ready  = reset & grant_smem & can_load;
    cache_fire          = cache_bus.rsp_valid & cache_bus.rsp_ready;
    smem_fire           = smem_bus.rsp_valid & smem_bus.rsp_ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_tmask_q <= '0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
    end else begin
      if (cache_fire) begin
        rr_q        <= 1'b1;
        rsp_valid_q <= 1'b1;
        rsp_tmask_q <= cache_bus.rsp_tmask;
        rsp_data_q  <= cache_bus.rsp_data;
        rsp_tag_q   <= cache_bus.rsp_tag;
      end else if (smem_fire) begin
        rr_q        <= 1'b0;
        rsp_valid_q <= 1'b1;
        rsp_tmask_q <= smem_bus.rsp_tmask;
        rsp_data_q  <= smem_bus.rsp_data;
        rsp_tag_q   <= smem_bus.rsp_tag;
      end else if (core_bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign core_bus.rsp_valid = rsp_valid_q;
  assign core_bus.rsp_tmask = rsp_tmask_q;
  assign core_bus.rsp_data  = rsp_data_q;
  assign core_bus.rsp_tag   = rsp_tag_q;

`ifdef VX_SMEM_SWITCH_PERF_EN
  localparam int unsigned CtrW = `PERF_CTR_BITS;
  logic [CtrW-1:0] rd_cnt_q, wr_cnt_q, rd_inc, wr_inc;

  always_comb begin
    rd_inc = '0;
    wr_inc = '0;
    for (int i = 0; i < int'(NUM_REQS); i++) begin
      if (buf_pop[1][i]) begin
        if (buf_head[1][i][PayW-1]) wr_inc = wr_inc + CtrW'(1);
        else                        rd_inc = rd_inc + CtrW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_q + rd_inc;
      wr_cnt_q <= wr_cnt_q + wr_inc;
    end
  end

  assign perf_smem_reads  = rd_cnt_q;
  assign perf_smem_writes = wr_cnt_q;
`endif
endmodule

// File: tb/tb_vx_smem_switch.sv
// Self-checking bench for vx_smem_switch: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the routing, buffering and response merge.
`ifdef VX_SMEM_SWITCH_PERF_EN
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif
`endif

module tb_vx_smem_switch;
  localparam int unsigned NR = 4;
  localparam int unsigned WS = 4;
  localparam int unsigned TW = 16;
  localparam int unsigned PW = 1 + 30 + WS + 8 * WS + TW;
  typedef logic [PW-1:0] pay_t;

  localparam logic [TW-1:0] CacheTag = 16'hCA10;
  localparam logic [TW-1:0] SmemTag  = 16'h5E21;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vx_smem_switch_if #(.NUM_REQS(NR), .WORD_SIZE(WS), .TAG_WIDTH(TW)) core_bus ();
  vx_smem_switch_if #(.NUM_REQS(NR), .WORD_SIZE(WS), .TAG_WIDTH(TW)) cache_bus ();
  vx_smem_switch_if #(.NUM_REQS(NR), .WORD_SIZE(WS), .TAG_WIDTH(TW)) smem_bus ();

`ifdef VX_SMEM_SWITCH_PERF_EN
  logic [`PERF_CTR_BITS-1:0] perf_smem_reads, perf_smem_writes;
`endif

  vx_smem_switch #(.NUM_REQS(NR), .WORD_SIZE(WS), .TAG_WIDTH(TW)) dut (
    .clk       (clk),
    .reset     (reset),
    .core_bus  (core_bus),
    .cache_bus (cache_bus),
    .smem_bus  (smem_bus)
`ifdef VX_SMEM_SWITCH_PERF_EN
    ,
    .perf_smem_reads  (perf_smem_reads),
    .perf_smem_writes (perf_smem_writes)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one FIFO per (port, lane), index port*NR+lane; a single held response.
  pay_t                    mq [8][$];
  bit                      m_rsp_valid = 1'b0;
  logic [NR-1:0]           m_tmask;
  logic [NR-1:0][8*WS-1:0] m_data;
  logic [TW-1:0]           m_tag;
  bit                      last_smem = 1'b1;  // cache wins the first tie
  logic [63:0]             m_reads = '0;
  logic [63:0]             m_writes = '0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pay_t core_pay(input int i);
    return {core_bus.req_rw[i], core_bus.req_addr[i], core_bus.req_byteen[i],
            core_bus.req_data[i], core_bus.req_tag[i]};
  endfunction

  function automatic pay_t out_pay(input int p, input int i);
    if (p == 0)
      return {cache_bus.req_rw[i], cache_bus.req_addr[i], cache_bus.req_byteen[i],
              cache_bus.req_data[i], cache_bus.req_tag[i]};
    return {smem_bus.req_rw[i], smem_bus.req_addr[i], smem_bus.req_byteen[i],
            smem_bus.req_data[i], smem_bus.req_tag[i]};
  endfunction

  task automatic idle();
    core_bus.req_valid  = '0;
    core_bus.req_rw     = '0;
    core_bus.req_addr   = '0;
    core_bus.req_byteen = '0;
    core_bus.req_data   = '0;
    core_bus.req_tag    = '0;
    core_bus.rsp_ready  = 1'b1;
    cache_bus.req_ready = '1;
    smem_bus.req_ready  = '1;
    cache_bus.rsp_valid = 1'b0;
    cache_bus.rsp_tmask = '0;
    cache_bus.rsp_data  = '0;
    cache_bus.rsp_tag   = '0;
    smem_bus.rsp_valid  = 1'b0;
    smem_bus.rsp_tmask  = '0;
    smem_bus.rsp_data   = '0;
    smem_bus.rsp_tag    = '0;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NR; i++) begin
      core_bus.req_valid[i]  = ($urandom_range(0, 3) != 0);
      core_bus.req_rw[i]     = 1'($urandom);
      core_bus.req_addr[i]   = 30'($urandom);
      core_bus.req_byteen[i] = WS'($urandom);
      core_bus.req_data[i]   = $urandom;
      core_bus.req_tag[i]    = TW'($urandom);
      cache_bus.req_ready[i] = ($urandom_range(0, 3) != 0);
      smem_bus.req_ready[i]  = ($urandom_range(0, 2) != 0);
      cache_bus.rsp_data[i]  = $urandom;
      smem_bus.rsp_data[i]   = $urandom;
    end
    cache_bus.rsp_valid = 1'($urandom);
    cache_bus.rsp_tmask = NR'($urandom);
    cache_bus.rsp_tag   = TW'($urandom);
    smem_bus.rsp_valid  = 1'($urandom);
    smem_bus.rsp_tmask  = NR'($urandom);
    smem_bus.rsp_tag    = TW'($urandom);
    core_bus.rsp_ready  = ($urandom_range(0, 3) != 0);
  endtask

  // One cycle: check outputs shortly after the falling edge, advance the model on the rising
  // edge, return on the next falling edge.
  task automatic step();
    bit [NR-1:0]      exp_rdy;
    bit [1:0][NR-1:0] down;
    bit               can_load;
    int               winner;  // 0 none, 1 cache, 2 smem
    int               p, k;
    pay_t             popped;
    #1;
    if (!reset) begin
      for (int j = 0; j < 8; j++) mq[j].delete();
      m_rsp_valid = 1'b0;
      last_smem   = 1'b1;
      m_reads     = '0;
      m_writes    = '0;
    end
    for (int i = 0; i < NR; i++) begin
      down[0][i] = cache_bus.req_ready[i];
      down[1][i] = smem_bus.req_ready[i];
    end
    for (int i = 0; i < NR; i++) begin
      p = int'(core_bus.req_tag[i][0]);
      k = p * NR + i;
      exp_rdy[i] = reset && (mq[k].size() < 2 || down[p][i]);
      check_eq($sformatf("core_req_ready[%0d]", i), core_bus.req_ready[i], exp_rdy[i]);
    end
    for (int q = 0; q < 2; q++) begin
      for (int i = 0; i < NR; i++) begin
        k = q * NR + i;
        check_eq($sformatf("req_valid p%0d l%0d", q, i),
                 q == 0 ? cache_bus.req_valid[i] : smem_bus.req_valid[i], mq[k].size() > 0);
        if (mq[k].size() > 0)
          check_eq($sformatf("req_payload p%0d l%0d", q, i), out_pay(q, i), mq[k][0]);
      end
    end

    if (cache_bus.rsp_valid && smem_bus.rsp_valid) winner = last_smem ? 1 : 2;
    else if (cache_bus.rsp_valid)                  winner = 1;
    else if (smem_bus.rsp_valid)                   winner = 2;
    else                                           winner = 0;
    can_load = !m_rsp_valid || core_bus.rsp_ready;
    if (!reset) begin
      check_eq("cache_rsp_ready in reset", cache_bus.rsp_ready, 0);
      check_eq("smem_rsp_ready in reset", smem_bus.rsp_ready, 0);
    end else begin
      if (cache_bus.rsp_valid)
        check_eq("cache_rsp_ready", cache_bus.rsp_ready, (winner == 1) && can_load);
      if (smem_bus.rsp_valid)
        check_eq("smem_rsp_ready", smem_bus.rsp_ready, (winner == 2) && can_load);
    end
    check_eq("core_rsp_valid", core_bus.rsp_valid, m_rsp_valid);
    if (m_rsp_valid) begin
      check_eq("core_rsp_tmask", core_bus.rsp_tmask, m_tmask);
      check_eq("core_rsp_data", core_bus.rsp_data, m_data);
      check_eq("core_rsp_tag", core_bus.rsp_tag, m_tag);
    end
`ifdef VX_SMEM_SWITCH_PERF_EN
    check_eq("perf_smem_reads", perf_smem_reads, m_reads[`PERF_CTR_BITS-1:0]);
    check_eq("perf_smem_writes", perf_smem_writes, m_writes[`PERF_CTR_BITS-1:0]);
`endif

    @(posedge clk);
    if (reset) begin
      for (int q = 0; q < 2; q++) begin
        for (int i = 0; i < NR; i++) begin
          k = q * NR + i;
          if (mq[k].size() > 0 && down[q][i]) begin
            popped = mq[k].pop_front();
            if (q == 1) begin
              if (popped[PW-1]) m_writes = m_writes + 1;
              else              m_reads  = m_reads + 1;
            end
          end
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (core_bus.req_valid[i] && exp_rdy[i])
          mq[int'(core_bus.req_tag[i][0]) * NR + i].push_back(core_pay(i));
      end
      if (m_rsp_valid && core_bus.rsp_ready) m_rsp_valid = 1'b0;
      if (winner != 0 && can_load) begin
        m_rsp_valid = 1'b1;
        last_smem   = (winner == 2);
        m_tmask     = (winner == 1) ? cache_bus.rsp_tmask : smem_bus.rsp_tmask;
        m_data      = (winner == 1) ? cache_bus.rsp_data : smem_bus.rsp_data;
        m_tag       = (winner == 1) ? cache_bus.rsp_tag : smem_bus.rsp_tag;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    #2 reset = 1'b0;
    @(negedge clk);
    step();
    step();
    reset = 1'b1;
    step();

    // Routing by tag bit 0.
    core_bus.req_valid[0] = 1'b1;
    core_bus.req_tag[0]   = 16'h0011;
    core_bus.req_addr[0]  = 30'h0ABCDE1;
    core_bus.req_data[0]  = 32'hDEADBEEF;
    core_bus.req_valid[1] = 1'b1;
    core_bus.req_tag[1]   = 16'h0022;
    core_bus.req_addr[1]  = 30'h0ABCDE1;
    core_bus.req_data[1]  = 32'hDEADBEEF;
    step();
    idle();
    check_eq("route smem l0 valid", smem_bus.req_valid[0], 1);
    check_eq("route cache l1 valid", cache_bus.req_valid[1], 1);
    check_eq("route cache l0 idle", cache_bus.req_valid[0], 0);
    check_eq("route smem l1 idle", smem_bus.req_valid[1], 0);
    check_eq("route smem l0 addr", smem_bus.req_addr[0], 30'h0ABCDE1);
    check_eq("route cache l1 data", cache_bus.req_data[1], 32'hDEADBEEF);
    step();

    // Lane-2 smem backpressure: two accepted, third stalls, then in-order drain.
    smem_bus.req_ready[2] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      core_bus.req_valid[2] = 1'b1;
      core_bus.req_tag[2]   = 16'h0001;
      core_bus.req_addr[2]  = 30'(100 + n);
      #1;
      check_eq("bp core_req_ready[2]", core_bus.req_ready[2], n < 2);
      step();
    end
    check_eq("bp head", smem_bus.req_addr[2], 30'd100);
    smem_bus.req_ready[2] = 1'b1;
    step();
    core_bus.req_valid[2] = 1'b0;
    check_eq("bp drain 1", smem_bus.req_addr[2], 30'd101);
    step();
    check_eq("bp drain 2", smem_bus.req_addr[2], 30'd102);
    step();
    check_eq("bp drained", smem_bus.req_valid[2], 0);

    // Response round-robin with both sources valid.
    cache_bus.rsp_valid = 1'b1;
    cache_bus.rsp_tag   = CacheTag;
    cache_bus.rsp_tmask = 4'b0011;
    smem_bus.rsp_valid  = 1'b1;
    smem_bus.rsp_tag    = SmemTag;
    smem_bus.rsp_tmask  = 4'b1100;
    for (int n = 0; n < 4; n++) begin
      step();
      check_eq("rr grant", core_bus.rsp_tag, (n % 2 == 0) ? CacheTag : SmemTag);
    end

    // Hold under core_rsp_ready=0.
    core_bus.rsp_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      cache_bus.rsp_tag = TW'($urandom);
      step();
      check_eq("hold valid", core_bus.rsp_valid, 1);
      check_eq("hold tag", core_bus.rsp_tag, SmemTag);
      check_eq("hold tmask", core_bus.rsp_tmask, 4'b1100);
      check_eq("hold cache ready", cache_bus.rsp_ready, 0);
      check_eq("hold smem ready", smem_bus.rsp_ready, 0);
    end
    idle();
    step();

`ifdef VX_SMEM_SWITCH_PERF_EN
    begin
      logic [63:0] w0;
      w0 = m_writes;
      for (int i = 0; i < NR; i++) begin
        core_bus.req_valid[i] = 1'b1;
        core_bus.req_rw[i]    = 1'b1;
        core_bus.req_tag[i]   = 16'h0001;
      end
      step();
      idle();
      step();
      check_eq("perf writes +4", perf_smem_writes, w0[`PERF_CTR_BITS-1:0] + 4);
    end
`endif

    // Reset with requests buffered and a response held.
    cache_bus.req_ready   = '0;
    core_bus.req_valid[0] = 1'b1;
    cache_bus.rsp_valid   = 1'b1;
    cache_bus.rsp_tag     = CacheTag;
    core_bus.rsp_ready    = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    idle();
    step();
    check_eq("post-reset cache valid", cache_bus.req_valid[0], 0);
    check_eq("post-reset rsp valid", core_bus.rsp_valid, 0);
`ifdef VX_SMEM_SWITCH_PERF_EN
    check_eq("post-reset reads", perf_smem_reads, 0);
    check_eq("post-reset writes", perf_smem_writes, 0);
`endif

    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      reset = ($urandom_range(0, 399) != 0);
      step();
    end
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
